wide_add_seq: RTL
=================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter NBEATS, default 4: number of 8-bit slices per operation; operand width W = 8*NBEATS (32 at default).
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1: requester n has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1: operation accepted on this edge when valid is also high.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, W: operands.
REQ-007 SHALL have port resp_valid, output, 1: result available.
REQ-008 SHALL have port resp_ready, input, 1: consumer takes the result.
REQ-009 SHALL have port resp_sum, output, W: a+b mod 2^W.
REQ-010 SHALL have port resp_cout, output, 1: carry out of bit W-1.
REQ-011 SHALL have port resp_id, output, 1: index of the requester that issued the result.

Function
REQ-012 SHALL time-share one 8-bit carry-select slice; slice k (bits 8k+7:8k) SHALL be added on beat k, LSB slice first.
REQ-013 SHALL use the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 IDLE: assert ready to exactly one requester: the single valid one, or the higher-priority one when both are valid; on handshake, capture a, b and id, clear beat counter and carry register, go to RUN.
REQ-015 ready SHALL be low for both requesters in RUN and DONE, and for any requester whose valid is low.
REQ-016 RUN: each cycle SHALL add slice[beat] of a and b with the carry register as cin; it SHALL store the 8-bit sum into the result register at slice[beat] and the slice cout into the carry register.
REQ-017 RUN: beat counter SHALL increment each cycle; after beat NBEATS-1 go to DONE and set resp_cout from the final slice carry.
REQ-018 Latency: accept on edge E0, beats on edges E1..E(NBEATS); resp_valid SHALL be high in the cycle after E(NBEATS), i.e. NBEATS+1 cycles after accept.
REQ-019 DONE: resp_valid SHALL be high and resp_sum/resp_cout/resp_id SHALL be held stable until resp_ready is high; on that edge return to IDLE.
REQ-020 Arbitration SHALL be round-robin: after a grant to requester n, priority SHALL pass to the other requester; priority SHALL not change without a grant.
REQ-021 Captured operands SHALL be unaffected by requester input changes after accept.
REQ-022 Carry SHALL propagate across all beats. There is no approximation: the result is exact for all operand values, including all-ones inputs.
REQ-023 Minimum issue interval SHALL be NBEATS+2 cycles (accept, NBEATS beats, response); IDLE SHALL accept in the same cycle it is entered.

Reset
REQ-024 When rst is high, state SHALL be IDLE, beat counter 0, carry 0, and result register, resp_cout and resp_id 0.
REQ-025 When rst is high, resp_valid SHALL be 0, and priority SHALL be req0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no response; the first accept after release SHALL follow REQ-014 with req0 priority.
REQ-027 ready outputs SHALL be low while rst is high.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE), SLICE_W = 8 and the beat-counter width $clog2(NBEATS).
REQ-029 One sub-module SHALL exist: csel_slice8, a combinational 8-bit carry-select adder with inputs a[7:0], b[7:0], cin and outputs sum[7:0], cout, built from 2-bit blocks precomputed for both carry values.
REQ-030 All registers SHALL be in wide_add_seq; csel_slice8 SHALL have no state.

Verification
REQ-031 req0: 0xFFFFFFFF + 0x00000001 -> resp_sum 0x00000000, resp_cout 1, resp_id 0, resp_valid exactly 5 cycles after accept.
REQ-032 req1: 0x12345678 + 0x11111111 -> resp_sum 0x23456789, resp_cout 0, resp_id 1.
REQ-033 Both valid, held high from reset release -> grant order req0, req1, req0; ready low to both during RUN/DONE.
REQ-034 resp_ready low for 3 cycles in DONE -> resp_valid, resp_sum and resp_id stay stable; return to IDLE on the edge where resp_ready is high.
REQ-035 rst pulse on beat 2 of an operation -> no resp_valid; next operation 0x80000000 + 0x80000000 -> sum 0x00000000, cout 1.
REQ-036 Operands changed on the cycle after accept -> result reflects the captured values.

Source files
------------

// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the time-shared wide adder.
//   state_t     : sequencer states (IDLE -> RUN -> DONE -> IDLE)
//   SLICE_W     : width of the single adder slice reused on every beat
//   beat_cnt_w  : beat-counter width for a given beat count
package wide_add_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // $clog2(nbeats), held at 1 so a single-beat build still has a legal counter.
  function automatic int beat_cnt_w(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_csel.sv
// csel_slice8: purely combinational 8-bit carry-select adder.
//   a, b : 8-bit operands
//   cin  : carry in
//   sum  : 8-bit sum
//   cout : carry out of bit 7
// Each 2-bit block is summed for both possible incoming carries up front;
// the ripple path then only steers through one mux per block.
module csel_slice8
  import wide_add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int NBLK = SLICE_W / 2;

  // {carry, sum[1:0]} of each block assuming carry-in 0 and carry-in 1
  logic [2:0] blk_r0 [NBLK];
  logic [2:0] blk_r1 [NBLK];

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
    assign blk_r0[gi] = {1'b0, a[2*gi +: 2]} + {1'b0, b[2*gi +: 2]};
    assign blk_r1[gi] = blk_r0[gi] + 3'd1;
  end

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < NBLK; i++) begin
      sum[2*i +: 2] = c ? blk_r1[i][1:0] : blk_r0[i][1:0];
      c             = c ? blk_r1[i][2]   : blk_r0[i][2];
    end
    cout = c;
  end

endmodule

// File: rtl/wide_add_seq.sv
// wide_add_seq: two-requester W-bit adder (W = 8*NBEATS) that reuses one
// 8-bit carry-select slice, LSB slice first, one slice per clock.
//   clk, rst              : clock (rising edge), async active-high reset
//   reqN_valid/reqN_ready : request handshake for requester N (0/1)
//   reqN_a, reqN_b        : operands from requester N
//   resp_valid/resp_ready : result handshake
//   resp_sum, resp_cout   : a+b mod 2^W and carry out of bit W-1
//   resp_id               : requester that issued the result
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int NBEATS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [SLICE_W*NBEATS-1:0] req0_a,
  input  logic [SLICE_W*NBEATS-1:0] req0_b,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [SLICE_W*NBEATS-1:0] req1_a,
  input  logic [SLICE_W*NBEATS-1:0] req1_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [SLICE_W*NBEATS-1:0] resp_sum,
  output logic                    resp_cout,
  output logic                    resp_id
);

  localparam int W  = SLICE_W * NBEATS;
  localparam int BW = beat_cnt_w(NBEATS);

  state_t         state_reg, state_next;
  logic [BW-1:0]  beat_reg;
  logic           carry_reg;
  logic [W-1:0]   a_reg, b_reg, sum_reg;
  logic           cout_reg, id_reg;
  logic           prio_reg;   // 1: requester 1 wins a tie

  logic [SLICE_W-1:0] a_slices [NBEATS];
  logic [SLICE_W-1:0] b_slices [NBEATS];
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               last_beat;
  logic               accept;

  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_slices
    assign a_slices[gi] = a_reg[gi*SLICE_W +: SLICE_W];
    assign b_slices[gi] = b_reg[gi*SLICE_W +: SLICE_W];
  end

  csel_slice8 u_slice (
    .a    (a_slices[beat_reg]),
    .b    (b_slices[beat_reg]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign last_beat = (beat_reg == BW'(NBEATS - 1));
  assign accept    = req0_ready | req1_ready;

  // Next state and handshake outputs. Ready is also gated by rst because
  // the reset is asynchronous and the state register may not yet reflect it.
  always_comb begin
    state_next = state_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!rst) begin
          req0_ready = req0_valid && (!req1_valid || !prio_reg);
          req1_ready = req1_valid && (!req0_valid ||  prio_reg);
        end
        if (req0_ready || req1_ready) state_next = RUN;
      end
      RUN:     if (last_beat)  state_next = DONE;
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      id_reg    <= 1'b0;
      prio_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= req1_ready ? req1_a : req0_a;
            b_reg     <= req1_ready ? req1_b : req0_b;
            id_reg    <= req1_ready;
            prio_reg  <= req0_ready;  // priority moves to the one not served
            beat_reg  <= '0;
            carry_reg <= 1'b0;
          end
        end
        RUN: begin
          beat_reg  <= beat_reg + 1'b1;
          carry_reg <= slice_cout;
          for (int k = 0; k < NBEATS; k++) begin
            if (beat_reg == BW'(k)) sum_reg[k*SLICE_W +: SLICE_W] <= slice_sum;
          end
          if (last_beat) cout_reg <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state_reg == DONE);
  assign resp_sum   = sum_reg;
  assign resp_cout  = cout_reg;
  assign resp_id    = id_reg;

endmodule
